// File: rtl/serial_adder_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_pkg
// Shared definitions for the bit-serial adder controller.
//   state_e       : controller FSM states (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH : default operand width in bits
// ---------------------------------------------------------------------------
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : serial_adder_ctrl_pkg

// File: rtl/serial_adder_ctrl_fulladder.sv
// ---------------------------------------------------------------------------
// fulladder
// One-bit full adder used as the arithmetic core of the serial adder.
// Ports:
//   a_i, b_i : operand bits
//   c_i      : carry in
//   s_o      : sum bit
//   co_o     : carry out
// ---------------------------------------------------------------------------
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule : fulladder

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in, LSB first,
// one bit per clock through a single one-bit full adder.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset
//   start  : begin an addition (honoured in IDLE and DONE only)
//   a, b   : operands, captured when start is accepted
//   cin    : carry-in, captured when start is accepted
//   busy   : high while shifting
//   done   : one-cycle pulse, sum/cout valid
//   sum    : registered result of the last completed addition
//   cout   : registered carry-out of the last completed addition
// ---------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   psum_q, psum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               fa_s;
  logic               fa_co;

  fulladder u_fa (
    .a_i  (opa_q[0]),
    .b_i  (opb_q[0]),
    .c_i  (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          psum_d  = {WIDTH{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        // start is deliberately not looked at here: no restart while busy.
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        psum_d  = {fa_s, psum_q[WIDTH-1:1]};
        carry_d = fa_co;
        if (cnt_q == LAST_CNT) begin
          // Publish the completed word directly so sum never shows a partial value;
          // the counter holds here instead of wrapping.
          state_d = DONE;
          sum_d   = {fa_s, psum_q[WIDTH-1:1]};
          cout_d  = fa_co;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (start) begin
          state_d = SHIFT;
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          psum_d  = {WIDTH{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered from the next state so they align with it.
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= {WIDTH{1'b0}};
      opb_q   <= {WIDTH{1'b0}};
      psum_q  <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=2.
// Expected {cout,sum} values are queued when an operation is started and
// compared whenever the corresponding DUT pulses done.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start2, cin2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  int tests_run;
  int tests_failed;

  logic [8:0] q8[$];
  logic [2:0] q2[$];

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .cin   (cin2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard for the 8-bit instance.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        check_val("spurious_done8", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = q8.pop_front();
        check_val("sum8", {24'd0, sum8}, {24'd0, e[7:0]});
        check_val("cout8", {31'd0, cout8}, {31'd0, e[8]});
      end
    end
  end

  // Scoreboard for the 2-bit instance.
  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        check_val("spurious_done2", 32'd1, 32'd0);
      end else begin
        logic [2:0] e;
        e = q2.pop_front();
        check_val("sum2", {30'd0, sum2}, {30'd0, e[1:0]});
        check_val("cout2", {31'd0, cout2}, {31'd0, e[2]});
      end
    end
  end

  // One 8-bit operation: start, scramble inputs, wait for done, check latency.
  task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    int lat;
    @(negedge clk);
    start8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
    q8.push_back({1'b0, ta} + {1'b0, tb} + {8'd0, tc});
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom_range(0, 255));
    b8 = 8'($urandom_range(0, 255));
    cin8 = 1'($urandom_range(0, 1));
    lat = -1;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      if (done8) begin
        lat = k;
        break;
      end
    end
    check_val("lat8", 32'(lat), 32'd8);
  endtask

  // One 2-bit operation, same shape as run_op8.
  task automatic run_op2(input logic [1:0] ta, input logic [1:0] tb, input logic tc);
    int lat;
    @(negedge clk);
    start2 = 1'b1; a2 = ta; b2 = tb; cin2 = tc;
    q2.push_back({1'b0, ta} + {1'b0, tb} + {2'd0, tc});
    @(negedge clk);
    start2 = 1'b0;
    a2 = 2'($urandom_range(0, 3));
    b2 = 2'($urandom_range(0, 3));
    cin2 = 1'($urandom_range(0, 1));
    lat = -1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (done2) begin
        lat = k;
        break;
      end
    end
    check_val("lat2", 32'(lat), 32'd2);
  endtask

  initial begin
    int first;
    int second;
    bit saw_busy;
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start2 = 1'b0; a2 = 2'd0; b2 = 2'd0; cin2 = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_val("rst_busy8", {31'd0, busy8}, 32'd0);
    check_val("rst_done8", {31'd0, done8}, 32'd0);
    check_val("rst_sum8", {24'd0, sum8}, 32'd0);
    check_val("rst_cout8", {31'd0, cout8}, 32'd0);
    check_val("rst_busy2", {31'd0, busy2}, 32'd0);
    check_val("rst_sum2", {30'd0, sum2}, 32'd0);
    rst_n = 1'b1;

    // Directed arithmetic cases.
    run_op8(8'h5A, 8'h3C, 1'b0);
    run_op8(8'hFF, 8'h01, 1'b0);
    run_op8(8'hFF, 8'hFF, 1'b1);

    // Result must hold between done pulses.
    repeat (3) @(negedge clk);
    check_val("hold_sum8", {24'd0, sum8}, 32'hFF);
    check_val("hold_cout8", {31'd0, cout8}, 32'd1);

    // start while busy is ignored.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
    q8.push_back(9'h002);
    @(negedge clk);
    start8 = 1'b0;
    first = -1;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 2) begin
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1;
      end
      if (k == 3) begin
        start8 = 1'b0;
        check_val("busy_during_ignore", {31'd0, busy8}, 32'd1);
      end
      if (done8) begin
        first = k;
        break;
      end
    end
    check_val("lat_ignore", 32'(first), 32'd8);
    repeat (12) @(negedge clk);

    // Reset in the middle of SHIFT aborts without done.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    saw_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      if (busy8) saw_busy = 1'b1;
      if (k == 3) rst_n = 1'b0;
    end
    check_val("busy_before_rst", {31'd0, saw_busy}, 32'd1);
    @(negedge clk);
    check_val("midrst_busy8", {31'd0, busy8}, 32'd0);
    check_val("midrst_done8", {31'd0, done8}, 32'd0);
    check_val("midrst_sum8", {24'd0, sum8}, 32'd0);
    check_val("midrst_cout8", {31'd0, cout8}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_val("midrst_no_done", {31'd0, done8}, 32'd0);
    run_op8(8'h10, 8'h20, 1'b0);

    // Back-to-back: start held through DONE restarts with no IDLE cycle.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
    q8.push_back(9'h010);
    q8.push_back(9'h010);
    @(negedge clk);
    first = -1;
    second = -1;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clk);
      if (first >= 0 && k == first + 1) begin
        start8 = 1'b0;
        check_val("b2b_busy", {31'd0, busy8}, 32'd1);
      end
      if (done8) begin
        if (first < 0) begin
          first = k;
        end else begin
          second = k;
          break;
        end
      end
    end
    start8 = 1'b0;
    check_val("b2b_first", 32'(first), 32'd8);
    check_val("b2b_second", 32'(second), 32'd17);

    // Random operands, both widths.
    for (int i = 0; i < 1000; i++) begin
      run_op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 1000; i++) begin
      run_op2(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check_val("sb_drain8", 32'(q8.size()), 32'd0);
    check_val("sb_drain2", 32'(q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_serial_adder_ctrl
